// File: rtl/motion_pkg.sv
// Shared types and constants for the gamepad motion detector.
package motion_pkg;

   typedef enum logic [2:0] {
      CALIB,
      IDLE,
      DOWN_CNT,
      UP_CNT,
      REFRACT,
      REARM
   } state_e;

   typedef enum logic {
      DIR_DOWN,
      DIR_UP
   } dir_e;

   localparam int unsigned CALIB_SAMPLES = 16;
   localparam int unsigned CALIB_SHIFT   = 4;
   localparam int unsigned CALIB_CNT_W   = $clog2(CALIB_SAMPLES);

endpackage

// File: rtl/motion_refract_timer.sv
// Refractory down-counter: load CYC, count down while running, stop at zero.
// o_done_c is high on the last running cycle so the owner leaves REFRACT
// after exactly CYC clocks.
module motion_refract_timer #(
   parameter int unsigned CYC = 5000000
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_load,
   input  logic i_run,
   output logic o_done_c
);

   localparam int unsigned CNT_W = (CYC < 1) ? 1 : $clog2(CYC + 1);

   logic [CNT_W-1:0] r_cnt;

   // Counter register: clear has priority over load, load over run.
   always_ff @(posedge clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CNT_W'(CYC);
      end else if (i_run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_done_c = i_run && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/gamepad_motion_detector.sv
// Turns the accelerometer Y-axis sample stream into one-cycle down/up flick
// pulses with hold-count debounce, a refractory period and hysteresis re-arm.
// Optional macro MOTION_CALIB_EN: average the first 16 samples after reset
// into an offset that is subtracted from every later sample.
module gamepad_motion_detector
   import motion_pkg::*;
#(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned THRESH       = 4000,
   parameter int unsigned HYST         = 1000,
   parameter int unsigned HOLD_SAMPLES = 3,
   parameter int unsigned REFRACT_CYC  = 5000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_enable,
   input  logic              i_sample_valid,
   input  logic [DATA_W-1:0] i_sample,
   output logic              o_down_detected,
   output logic              o_up_detected,
   output logic              o_busy,
   output logic              o_calib_done
);

   localparam int unsigned HW = (HOLD_SAMPLES < 1) ? 1 : $clog2(HOLD_SAMPLES + 1);

   localparam logic signed [DATA_W:0] L_THR_P = (DATA_W+1)'(THRESH);
   localparam logic signed [DATA_W:0] L_THR_N = -L_THR_P;
   localparam logic signed [DATA_W:0] L_HYS_P = (DATA_W+1)'(HYST);
   localparam logic signed [DATA_W:0] L_HYS_N = -L_HYS_P;

   state_e                   r_state;
   logic [HW-1:0]            r_hold;
   logic                     r_down;
   logic                     r_up;
   logic                     r_busy;

   logic [DATA_W-1:0]        w_offset;
   logic signed [DATA_W:0]   w_v;
   logic                     w_q_dn;
   logic                     w_q_up;
   logic                     w_in_band;
   logic                     w_last;
   logic                     w_fire;
   dir_e                     w_fire_dir;
   logic                     w_done;

`ifdef MOTION_CALIB_EN
   localparam int unsigned SUM_W = DATA_W + CALIB_SHIFT;

   logic signed [SUM_W-1:0]  r_sum;
   logic [CALIB_CNT_W-1:0]   r_ccnt;
   logic [DATA_W-1:0]        r_offset;
   logic                     r_calib_done;
   logic signed [SUM_W-1:0]  w_sum_nxt;

   assign w_sum_nxt    = r_sum + $signed({{CALIB_SHIFT{i_sample[DATA_W-1]}}, i_sample});
   assign w_offset     = r_offset;
   assign o_calib_done = r_calib_done;
`else
   assign w_offset     = '0;
   assign o_calib_done = 1'b1;
`endif

   // Offset-corrected sample, one bit wider so the difference never overflows.
   assign w_v = $signed({i_sample[DATA_W-1], i_sample}) - $signed({w_offset[DATA_W-1], w_offset});

   assign w_q_dn    = i_sample_valid && (w_v <= L_THR_N);
   assign w_q_up    = i_sample_valid && (w_v >= L_THR_P);
   assign w_in_band = i_sample_valid && (w_v > L_HYS_N) && (w_v < L_HYS_P);
   assign w_last    = (r_hold == HW'(HOLD_SAMPLES - 1));

   // Fire decision for this edge; enable low cancels any pending pulse.
   always_comb begin
      w_fire     = 1'b0;
      w_fire_dir = DIR_DOWN;
      case (r_state)
         IDLE: begin
            if (HOLD_SAMPLES == 1) begin
               w_fire     = w_q_dn || w_q_up;
               w_fire_dir = w_q_up ? DIR_UP : DIR_DOWN;
            end
         end
         DOWN_CNT: begin
            w_fire     = w_q_dn && w_last;
            w_fire_dir = DIR_DOWN;
         end
         UP_CNT: begin
            w_fire     = w_q_up && w_last;
            w_fire_dir = DIR_UP;
         end
         default: ;
      endcase
      w_fire = w_fire && i_enable;
   end

   motion_refract_timer #(
      .CYC (REFRACT_CYC)
   ) u_refract (
      .clk      (clk),
      .i_rst    (rst_n),
      .i_clr    (!i_enable),
      .i_load   (w_fire),
      .i_run    (r_state == REFRACT),
      .o_done_c (w_done)
   );

   // Gesture FSM with registered pulses and busy flag.
   always_ff @(posedge clk) begin
      if (rst_n) begin
`ifdef MOTION_CALIB_EN
         r_state      <= CALIB;
         r_sum        <= '0;
         r_ccnt       <= '0;
         r_offset     <= '0;
         r_calib_done <= 1'b0;
`else
         r_state      <= IDLE;
`endif
         r_hold       <= '0;
         r_down       <= 1'b0;
         r_up         <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_down <= w_fire && (w_fire_dir == DIR_DOWN);
         r_up   <= w_fire && (w_fire_dir == DIR_UP);
         if (!i_enable) begin
            r_hold <= '0;
`ifdef MOTION_CALIB_EN
            // Calibration is frozen, not restarted, while disabled.
            if (r_state != CALIB) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
`else
            r_state <= IDLE;
            r_busy  <= 1'b0;
`endif
         end else if (w_fire) begin
            r_state <= REFRACT;
            r_hold  <= '0;
            r_busy  <= 1'b1;
         end else begin
            case (r_state)
`ifdef MOTION_CALIB_EN
               CALIB: begin
                  r_busy <= 1'b1;
                  if (i_sample_valid) begin
                     r_sum  <= w_sum_nxt;
                     r_ccnt <= r_ccnt + CALIB_CNT_W'(1);
                     if (r_ccnt == CALIB_CNT_W'(CALIB_SAMPLES - 1)) begin
                        r_offset     <= w_sum_nxt[SUM_W-1:CALIB_SHIFT];
                        r_calib_done <= 1'b1;
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                     end
                  end
               end
`endif
               IDLE: begin
                  if (w_q_dn) begin
                     r_state <= DOWN_CNT;
                     r_hold  <= HW'(1);
                     r_busy  <= 1'b1;
                  end else if (w_q_up) begin
                     r_state <= UP_CNT;
                     r_hold  <= HW'(1);
                     r_busy  <= 1'b1;
                  end
               end
               DOWN_CNT: begin
                  if (w_q_dn) begin
                     r_hold <= r_hold + HW'(1);
                  end else if (i_sample_valid) begin
                     r_state <= IDLE;
                     r_hold  <= '0;
                     r_busy  <= 1'b0;
                  end
               end
               UP_CNT: begin
                  if (w_q_up) begin
                     r_hold <= r_hold + HW'(1);
                  end else if (i_sample_valid) begin
                     r_state <= IDLE;
                     r_hold  <= '0;
                     r_busy  <= 1'b0;
                  end
               end
               REFRACT: begin
                  if (w_done) begin
                     r_state <= REARM;
                  end
               end
               REARM: begin
                  // The re-arming sample is consumed, never treated as a gesture start.
                  if (w_in_band) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_hold  <= '0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_down_detected = r_down;
   assign o_up_detected   = r_up;
   assign o_busy          = r_busy;

endmodule

// File: tb/tb_gamepad_motion_detector.sv
// Scoreboard bench for gamepad_motion_detector: a gesture-level reference
// model queues the expected outputs for every clock, a monitor compares them.
module tb_gamepad_motion_detector;

   localparam int DATA_W = 16;
   localparam int THRESH = 4000;
   localparam int HYST   = 1000;
   localparam int HOLD   = 3;
   localparam int RCYC   = 8;
`ifdef MOTION_CALIB_EN
   localparam int CALIB_N = 16;
`else
   localparam int CALIB_N = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              i_enable = 1'b0;
   logic              i_sample_valid = 1'b0;
   logic [DATA_W-1:0] i_sample = '0;
   logic              o_down_detected;
   logic              o_up_detected;
   logic              o_busy;
   logic              o_calib_done;

   always #5 clk = ~clk;

   gamepad_motion_detector #(
      .DATA_W       (DATA_W),
      .THRESH       (THRESH),
      .HYST         (HYST),
      .HOLD_SAMPLES (HOLD),
      .REFRACT_CYC  (RCYC)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_enable        (i_enable),
      .i_sample_valid  (i_sample_valid),
      .i_sample        (i_sample),
      .o_down_detected (o_down_detected),
      .o_up_detected   (o_up_detected),
      .o_busy          (o_busy),
      .o_calib_done    (o_calib_done)
   );

   typedef struct packed {
      logic down;
      logic up;
      logic busy;
      logic cdone;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: gesture run length, armed flag and refractory deadline.
   int   m_cyc = 0;
   int   m_calib_left = CALIB_N;
   int   m_sum = 0;
   int   m_off = 0;
   int   m_run = 0;
   int   m_ref_end = -1;
   bit   m_armed = 1'b1;

   task automatic model(input bit r, input bit en, input bit vl, input int s);
      exp_t e;
      int   v;
      bit   qd, qu;
      e = '0;
      v = s - m_off;
      if (r) begin
         m_calib_left = CALIB_N;
         m_sum = 0;
         m_off = 0;
         m_run = 0;
         m_armed = 1'b1;
         m_ref_end = -1;
      end else if (!en) begin
         m_run = 0;
         m_armed = 1'b1;
         m_ref_end = -1;
      end else if (m_calib_left > 0) begin
         if (vl) begin
            m_sum = m_sum + s;
            m_calib_left = m_calib_left - 1;
            if (m_calib_left == 0) m_off = m_sum >>> 4;
         end
      end else if (m_cyc <= m_ref_end) begin
         // refractory: samples ignored
      end else if (!m_armed) begin
         if (vl && v > -HYST && v < HYST) m_armed = 1'b1;
      end else if (vl) begin
         qd = (v <= -THRESH);
         qu = (v >= THRESH);
         if (qd && m_run <= 0) m_run = m_run - 1;
         else if (qu && m_run >= 0) m_run = m_run + 1;
         else m_run = 0;
         if (m_run == -HOLD || m_run == HOLD) begin
            e.down = (m_run < 0);
            e.up   = (m_run > 0);
            m_run = 0;
            m_armed = 1'b0;
            m_ref_end = m_cyc + RCYC;
         end
      end
      e.busy  = r ? 1'b0 : (m_calib_left > 0 || m_run != 0 || !m_armed);
      e.cdone = (m_calib_left == 0);
      exp_q.push_back(e);
      m_cyc = m_cyc + 1;
   endtask

   task automatic step(input bit r, input bit en, input bit vl, input int s);
      @(negedge clk);
      rst_n = r;
      i_enable = en;
      i_sample_valid = vl;
      i_sample = DATA_W'(s);
      model(r, en, vl, s);
   endtask

   task automatic smp(input int s);
      step(1'b0, 1'b1, 1'b1, s);
   endtask

   task automatic gap(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 0);
   endtask

   // Monitor: compare every registered output set against the queued expectation.
   int   mon_cyc = 0;
   exp_t mon_e;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if ({o_down_detected, o_up_detected, o_busy, o_calib_done} !== mon_e) begin
            errors++;
            $display("FAIL cyc%0d outputs: got down=%b up=%b busy=%b calib=%b, want down=%b up=%b busy=%b calib=%b",
                     mon_cyc, o_down_detected, o_up_detected, o_busy, o_calib_done,
                     mon_e.down, mon_e.up, mon_e.busy, mon_e.cdone);
         end
         mon_cyc++;
      end
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int pool[14] = '{-5000, 5000, -4000, 4000, -3999, 3999, -2000,
                    -1000, 1000, -999, 999, 0, 500, -32768};

   initial begin
      int last;
      bit r, en, vl;
      int s;

      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 0);
      gap(2);

      // Calibration at +1000, then -3000 samples, then CALIB-time flicks after a reset.
      for (int k = 0; k < 16; k++) smp(1000);
      gap(1);
      for (int k = 0; k < 3; k++) smp(-3000);
      gap(10);
      smp(1000);
      step(1'b1, 1'b1, 1'b0, 0);
      for (int k = 0; k < 3; k++) smp(-9000);
      for (int k = 0; k < 13; k++) smp(0);
      gap(2);

      // Basic down flick.
      for (int k = 0; k < 3; k++) smp(-5000);
      gap(10);
      smp(0);

      // Broken hold, then a clean flick.
      smp(-5000); smp(-5000); smp(-3999);
      for (int k = 0; k < 3; k++) smp(-5000);
      gap(10);
      smp(0);

      // Samples inside refract ignored, then an up flick.
      for (int k = 0; k < 6; k++) smp(-5000);
      gap(6);
      smp(0);
      for (int k = 0; k < 3; k++) smp(5000);
      gap(10);
      smp(0);

      // Stuck outside the hysteresis band, then re-arm.
      for (int k = 0; k < 3; k++) smp(-5000);
      gap(9);
      for (int k = 0; k < 4; k++) smp(-2000);
      smp(500);
      gap(2);

      // Enable dropped on the third sample; reset mid-refract.
      smp(-5000); smp(-5000);
      step(1'b0, 1'b0, 1'b1, -5000);
      gap(2);
      for (int k = 0; k < 3; k++) smp(-5000);
      gap(3);
      step(1'b1, 1'b1, 1'b0, 0);
      gap(2);

      // Exact threshold and hysteresis boundaries.
      for (int k = 0; k < 3; k++) smp(-4000);
      gap(9);
      smp(-1000); smp(1000); smp(-999);
      for (int k = 0; k < 3; k++) smp(4000);
      gap(9);
      smp(999);

      // Hold counts valid strobes only.
      smp(5000); gap(2); smp(5000); gap(1); smp(5000);
      gap(10);
      smp(0);

      // Opposite direction aborts without starting a new gesture.
      smp(-5000); smp(5000); smp(5000); smp(5000); smp(5000);
      gap(10);
      smp(0);

      // Randomised traffic with sticky sample values so gestures occur.
      last = 0;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 599) == 0);
         en = ($urandom_range(0, 49) != 0);
         vl = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 9) < 7) s = last;
         else if ($urandom_range(0, 9) == 0) s = int'($urandom_range(0, 65535)) - 32768;
         else s = pool[$urandom_range(0, 13)];
         last = s;
         step(r, en, vl, s);
      end

      gap(4);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
